mips_mem_arbiter: RTL
=====================

Name: mips_mem_arbiter

Overview:
- Shares one Avalon-MM-style memory port between the CPU's instruction-fetch requester and data (load/store) requester. This turns the Harvard core into a single-bus system.
- Sits between the CPU core and the external memory/bus wrapper. Sequences one transaction at a time and handles waitrequest.
- Signals per-requester completion so the core can stall until its access finishes.
- A timeout counter bounds each bus transaction and reports an error.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width (byteenable width = DATA_W/8)
- TIMEOUT, 255, maximum cycles a transfer may sit in waitrequest before it is aborted; must be ≥1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  instruction fetch request; held high until i_done
- i_addr  in  ADDR_W  fetch address; stable while i_req is high
- i_rdata  out  DATA_W  fetched word; valid while i_done is high
- i_done  out  1  one-cycle pulse: fetch complete
- d_read  in  1  data read request; held until d_done
- d_write  in  1  data write request; held until d_done
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_byteenable  in  DATA_W/8  store/load byte lanes
- d_rdata  out  DATA_W  load data; valid while d_done is high
- d_done  out  1  one-cycle pulse: data access complete
- err  out  1  one-cycle pulse alongside i_done/d_done when the transfer timed out or the request was illegal
- mem_address  out  ADDR_W  bus address
- mem_read  out  1  bus read strobe
- mem_write  out  1  bus write strobe
- mem_writedata  out  DATA_W  bus write data
- mem_byteenable  out  DATA_W/8  bus byte lanes
- mem_readdata  in  DATA_W  bus read data
- mem_waitrequest  in  1  bus stall

Behaviour:
- Reset values (applied at the first clk edge with reset high): state=IDLE, mem_read=mem_write=0, mem_address=0, mem_writedata=0, mem_byteenable=0, i_done=d_done=err=0, i_rdata=d_rdata=0, timeout count=0.
- Every mem_* output and every response output is registered.
- States: IDLE, BUS_I, BUS_D, RESP.
- IDLE arbitration:
  - Data has fixed priority, because a pending data access belongs to the instruction already fetched.
  - If d_read|d_write, latch d_addr, d_wdata and d_byteenable, then go to BUS_D.
  - Else if i_req, latch i_addr, force byteenable to all-ones, then go to BUS_I.
  - Else stay in IDLE.
- BUS_I / BUS_D:
  - Drive mem_read (or mem_write for a data write) with the latched address, data and byteenable.
  - The transfer completes on the first edge where a strobe is high and mem_waitrequest=0.
  - On completion, capture mem_readdata into i_rdata or d_rdata (reads only; d_rdata is unchanged on writes), drop the strobes, and go to RESP.
- RESP:
  - Pulse i_done or d_done for exactly 1 cycle, then return to IDLE.
  - The requester deasserts its request in the done cycle; IDLE then samples fresh requests on the next edge.
- Latency:
  - Request seen in IDLE at edge N.
  - Strobe high in cycle N+1.
  - With waitrequest=0, done pulses in cycle N+2.
  - Each waitrequest cycle adds one cycle.
- Timeout:
  - The counter increments every BUS cycle with mem_waitrequest=1.
  - When it reaches TIMEOUT, drop the strobe, leave the rdata registers unchanged, go to RESP, and pulse done together with err.
  - The counter clears on entry to BUS_I/BUS_D.
- Illegal request (d_read & d_write both high in IDLE): perform the write only and assert err with d_done.
- Simultaneous i_req and data request: the data access is served first; the fetch is served in the following IDLE.
- New requests arriving during BUS or RESP are not sampled until IDLE; the strobe is never interrupted except by reset or timeout.
- Reset mid-transfer: strobes drop at the reset edge, no done pulse, state returns to IDLE.
- mem_read and mem_write are never high together; at most one transaction is outstanding.

Decomposition:
- Shared package mips_pkg holds:
  - the arb_state_t enum (IDLE, BUS_I, BUS_D, RESP)
  - ADDR_W/DATA_W defaults
  - the BYTE_EN_ALL constant
- One natural sub-module: mips_arb_timeout, a loadable saturating counter with clear, enable and an expired flag. Everything else stays in mips_mem_arbiter.

Test Plan:
- Fetch, zero wait: i_req=1, i_addr=0xBFC00000, waitrequest=0, mem_readdata=0x2402000A → mem_read high 1 cycle at 0xBFC00000 with byteenable=4'hF; i_done pulses 2 cycles after the request with i_rdata=0x2402000A.
- Collision: i_req and d_read (d_addr=0x1000) rise together → bus shows read 0x1000 first, d_done fires, then read of i_addr, then i_done; never two strobes at once.
- Waitrequest stall: d_write addr 0x2000, wdata 0xDEADBEEF, byteenable 4'b0011, waitrequest high 3 cycles → mem_write held 4 cycles with stable address, data and byteenable; d_done 1 cycle after release; err=0.
- Timeout: TIMEOUT=4, waitrequest stuck high on a fetch → strobe drops after 4 wait cycles; i_done and err pulse together; next request is served normally.
- Illegal request: d_read=d_write=1 → single write transaction; d_done and err pulse together.
- Reset mid-transfer: reset asserted during BUS_D with waitrequest high → next cycle mem_read=mem_write=0, no done pulse, state IDLE; a subsequent i_req completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS single-bus memory arbiter.
//   arb_state_t : arbiter FSM states
//   ADDR_W_DEF / DATA_W_DEF : default bus widths
//   BYTE_EN_ALL : all-lanes byteenable; callers truncate it to their lane count
package mips_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic [63:0] BYTE_EN_ALL = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mips_arb_timeout.sv
// Loadable saturating cycle counter that bounds one bus transfer.
//   clk, reset : clock, synchronous active-high reset
//   clr        : clear the count to zero (highest priority)
//   load       : load load_val
//   load_val   : value for load
//   en         : count this cycle (saturates at LIMIT)
//   hit_c      : combinational; this enabled cycle brings the count to LIMIT
module mips_arb_timeout #(
    parameter  int unsigned LIMIT = 255,
    localparam int unsigned CNT_W = $clog2(LIMIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             hit_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear, then load, then saturating increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en && (count_q < CNT_W'(LIMIT))) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires on the enabled cycle whose increment reaches LIMIT.
    assign hit_c = en && (count_q >= CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one Avalon-MM style memory port between the instruction-fetch
// requester (i_*) and the data requester (d_*). One transfer at a time, data
// has fixed priority, each transfer is bounded by a waitrequest timeout.
//   clk, reset          : clock, synchronous active-high reset
//   i_req/i_addr        : fetch request, held until i_done
//   i_rdata/i_done      : fetched word and one-cycle completion pulse
//   d_read/d_write/...  : data request, held until d_done
//   d_rdata/d_done      : load data and one-cycle completion pulse
//   err                 : pulses with done on timeout or read+write request
//   mem_*               : registered bus master port
module mips_mem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_done,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_byteenable,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_done,
    output logic                  err,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    input  logic [DATA_W-1:0]     mem_readdata,
    input  logic                  mem_waitrequest
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam logic [BE_W-1:0] BE_ALL = BE_W'(BYTE_EN_ALL);

    arb_state_t        state_q,   state_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              mem_read_q,    mem_read_d;
    logic              mem_write_q,   mem_write_d;
    logic [DATA_W-1:0] mem_writedata_q, mem_writedata_d;
    logic [BE_W-1:0]   mem_byteenable_q, mem_byteenable_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_done_q,  i_done_d;
    logic              d_done_q,  d_done_d;
    logic              err_q,     err_d;
    logic              illegal_q, illegal_d;

    logic              to_clr_c;
    logic              to_en_c;
    logic              to_hit_c;

    // Counter restarts whenever IDLE launches a transfer; counts stalled bus cycles.
    assign to_clr_c = (state_q == IDLE) && (d_read || d_write || i_req);
    assign to_en_c  = ((state_q == BUS_I) || (state_q == BUS_D)) && mem_waitrequest;

    mips_arb_timeout #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clr      (to_clr_c),
        .load     (1'b0),
        .load_val ('0),
        .en       (to_en_c),
        .hit_c    (to_hit_c)
    );

    // Arbitration, bus sequencing and response generation.
    always_comb begin
        state_d          = state_q;
        mem_address_d    = mem_address_q;
        mem_read_d       = mem_read_q;
        mem_write_d      = mem_write_q;
        mem_writedata_d  = mem_writedata_q;
        mem_byteenable_d = mem_byteenable_q;
        i_rdata_d        = i_rdata_q;
        d_rdata_d        = d_rdata_q;
        illegal_d        = illegal_q;
        i_done_d         = 1'b0;
        d_done_d         = 1'b0;
        err_d            = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_read || d_write) begin
                    // A read+write request is served as the write alone.
                    mem_address_d    = d_addr;
                    mem_writedata_d  = d_wdata;
                    mem_byteenable_d = d_byteenable;
                    mem_write_d      = d_write;
                    mem_read_d       = !d_write;
                    illegal_d        = d_read && d_write;
                    state_d          = BUS_D;
                end else if (i_req) begin
                    mem_address_d    = i_addr;
                    mem_byteenable_d = BE_ALL;
                    mem_read_d       = 1'b1;
                    mem_write_d      = 1'b0;
                    illegal_d        = 1'b0;
                    state_d          = BUS_I;
                end
            end

            BUS_I, BUS_D: begin
                if (!mem_waitrequest || to_hit_c) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = RESP;
                    err_d       = illegal_q || mem_waitrequest;
                    if (state_q == BUS_I) begin
                        i_done_d = 1'b1;
                        if (!mem_waitrequest) begin
                            i_rdata_d = mem_readdata;
                        end
                    end else begin
                        d_done_d = 1'b1;
                        if (!mem_waitrequest && mem_read_q) begin
                            d_rdata_d = mem_readdata;
                        end
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            mem_address_q    <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= '0;
            mem_byteenable_q <= '0;
            i_rdata_q        <= '0;
            d_rdata_q        <= '0;
            i_done_q         <= 1'b0;
            d_done_q         <= 1'b0;
            err_q            <= 1'b0;
            illegal_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            mem_address_q    <= mem_address_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_writedata_q  <= mem_writedata_d;
            mem_byteenable_q <= mem_byteenable_d;
            i_rdata_q        <= i_rdata_d;
            d_rdata_q        <= d_rdata_d;
            i_done_q         <= i_done_d;
            d_done_q         <= d_done_d;
            err_q            <= err_d;
            illegal_q        <= illegal_d;
        end
    end

    assign mem_address    = mem_address_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_byteenable = mem_byteenable_q;
    assign i_rdata        = i_rdata_q;
    assign d_rdata        = d_rdata_q;
    assign i_done         = i_done_q;
    assign d_done         = d_done_q;
    assign err            = err_q;

endmodule
